// File: rtl/riio_pwr_seq_if.sv
// riio_pwr_seq_if: supply-good inputs and pad-ring control outputs of the power sequencer
interface riio_pwr_seq_if;
  logic       vddiox_ok_a;
  logic       vddio_ok_a;
  logic       down_req;
  logic       fault_clr;
  logic       pad_ret;
  logic       pad_ioen;
  logic       pwr_good;
  logic       down_ack;
  logic       fault;
  logic [2:0] state;
  modport master (
    input  vddiox_ok_a, vddio_ok_a, down_req, fault_clr,
    output pad_ret, pad_ioen, pwr_good, down_ack, fault, state
  );
  modport slave (
    output vddiox_ok_a, vddio_ok_a, down_req, fault_clr,
    input  pad_ret, pad_ioen, pwr_good, down_ack, fault, state
  );
endinterface

// File: rtl/riio_pwr_seq.sv
// riio_pwr_seq: orders pad retention and output-enable against VDDIOX/VDDIO supply-good
module riio_pwr_seq #(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 8,
  parameter int DEBOUNCE_CYC = 100,
  parameter int STEP_CYC     = 16
) (
  input  logic           clk,
  input  logic           rst,
  riio_pwr_seq_if.master bus
);
  typedef enum logic [2:0] {
    OFF, DEBOUNCE, REL_RET, EN_IO, ON, DIS_IO, SET_RET, DOWN
  } st_t;
  st_t                    state_q, state_d;
  logic [SYNC_STAGES-1:0] x_sync_q, io_sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   fault_q, fault_d;
  logic                   ret_q, ret_d;
  logic                   ioen_q, ioen_d;
  logic                   good_q, good_d;
  logic                   ack_q, ack_d;
  logic                   ok, brown, step_done, deb_done;
  assign ok        = x_sync_q[SYNC_STAGES-1] & io_sync_q[SYNC_STAGES-1];
  assign brown     = !ok && (state_q inside {REL_RET, EN_IO, ON, DIS_IO, SET_RET});
  assign step_done = cnt_q == CNT_W'(STEP_CYC - 1);
  assign deb_done  = cnt_q == CNT_W'(DEBOUNCE_CYC - 1);
  // State, counter, synchronizer and registered-output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= OFF;
      x_sync_q  <= '0;
      io_sync_q <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      fault_q   <= 1'b0;
      ret_q     <= 1'b1;
      ioen_q    <= 1'b0;
      good_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_sync_q  <= {x_sync_q[SYNC_STAGES-2:0], bus.vddiox_ok_a};
      io_sync_q <= {io_sync_q[SYNC_STAGES-2:0], bus.vddio_ok_a};
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      fault_q   <= fault_d;
      ret_q     <= ret_d;
      ioen_q    <= ioen_d;
      good_q    <= good_d;
      ack_q     <= ack_d;
    end
  end
  // Next state; brownout overrides every step, a power-down request seen early is held until ON
  always_comb begin
    state_d = state_q;
    if (brown) state_d = OFF;
    else
      case (state_q)
        OFF:      if (ok && !bus.down_req) state_d = DEBOUNCE;
        DEBOUNCE: state_d = !ok ? OFF : deb_done ? REL_RET : DEBOUNCE;
        REL_RET:  if (step_done) state_d = EN_IO;
        EN_IO:    if (step_done) state_d = ON;
        ON:       if (bus.down_req || pend_q) state_d = DIS_IO;
        DIS_IO:   if (step_done) state_d = SET_RET;
        SET_RET:  if (step_done) state_d = DOWN;
        DOWN:     if (!bus.down_req) state_d = OFF;
        default:  state_d = OFF;
      endcase
    cnt_d   = (state_d != state_q) ? '0
            : (state_q inside {DEBOUNCE, REL_RET, EN_IO, DIS_IO, SET_RET}) ? cnt_q + CNT_W'(1)
            : cnt_q;
    pend_d  = (state_d inside {OFF, DIS_IO}) ? 1'b0
            : (bus.down_req && (state_q inside {DEBOUNCE, REL_RET, EN_IO})) ? 1'b1
            : pend_q;
    fault_d = brown ? 1'b1 : bus.fault_clr ? 1'b0 : fault_q;
  end
  // Pad controls decoded from the state being entered so they change on the same edge
  always_comb begin
    ret_d  = !(state_d inside {REL_RET, EN_IO, ON, DIS_IO});
    ioen_d = state_d inside {EN_IO, ON};
    good_d = state_d == ON;
    ack_d  = state_d == DOWN;
  end
  assign bus.pad_ret  = ret_q;
  assign bus.pad_ioen = ioen_q;
  assign bus.pwr_good = good_q;
  assign bus.down_ack = ack_q;
  assign bus.fault    = fault_q;
  assign bus.state    = state_q;
endmodule

// File: tb/tb_riio_pwr_seq.sv
// tb_riio_pwr_seq: directed stimulus with a countdown-based reference model checked every cycle
module tb_riio_pwr_seq;
  localparam int SS  = 2;
  localparam int DEB = 4;
  localparam int STP = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  riio_pwr_seq_if bus ();
  riio_pwr_seq #(.SYNC_STAGES(SS), .CNT_W(8), .DEBOUNCE_CYC(DEB), .STEP_CYC(STP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_chk  = 0;
  int n_fail = 0;
  function automatic void chk(string name, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endfunction
  int ms = 0;
  int left = 0;
  bit mfault = 0;
  bit mpend = 0;
  bit valid = 0;
  bit hist[SS];
  int dur[8] = '{0, DEB, STP, STP, 0, STP, STP, 0};
  // Reference model: phase number plus cycles left in the timed phases
  always @(posedge clk) begin : model
    bit ok;
    int nxt;
    ok = hist[SS-1];
    if (rst) begin
      ms = 0;
      left = 0;
      mfault = 0;
      mpend = 0;
      for (int i = 0; i < SS; i++) hist[i] = 0;
      valid = 1;
    end else begin
      nxt = ms;
      if (!ok && ms >= 2 && ms <= 6) begin
        nxt = 0;
        mfault = 1;
      end else begin
        if (bus.fault_clr) mfault = 0;
        if (ms == 0) begin
          if (ok && !bus.down_req) nxt = 1;
        end else if (ms == 1 && !ok) nxt = 0;
        else if (ms == 4) begin
          if (bus.down_req || mpend) nxt = 5;
        end else if (ms == 7) begin
          if (!bus.down_req) nxt = 0;
        end else if (left == 1) nxt = ms + 1;
        else left--;
      end
      if (bus.down_req && ms >= 1 && ms <= 3) mpend = 1;
      if (nxt == 0 || nxt == 5) mpend = 0;
      if (nxt != ms) left = dur[nxt];
      ms = nxt;
      for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.vddiox_ok_a & bus.vddio_ok_a;
    end
  end
  // Every-cycle comparison against the model, plus the ioen-implies-released invariant
  always @(negedge clk) begin
    if (valid) begin
      chk("m_state", int'(bus.state), ms);
      chk("m_pad_ret", int'(bus.pad_ret), int'(ms < 2 || ms > 5));
      chk("m_pad_ioen", int'(bus.pad_ioen), int'(ms == 3 || ms == 4));
      chk("m_pwr_good", int'(bus.pwr_good), int'(ms == 4));
      chk("m_down_ack", int'(bus.down_ack), int'(ms == 7));
      chk("m_fault", int'(bus.fault), int'(mfault));
      chk("invariant", int'(bus.pad_ioen & bus.pad_ret), 0);
    end
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic wait_state(int s, int lim, string nm);
    int k = 0;
    while (int'(bus.state) != s && k < lim) begin
      tick();
      k++;
    end
    chk(nm, int'(bus.state), s);
  endtask
  task automatic chk_reset(string nm);
    chk({nm, "_state"}, int'(bus.state), 0);
    chk({nm, "_ret"}, int'(bus.pad_ret), 1);
    chk({nm, "_ioen"}, int'(bus.pad_ioen), 0);
    chk({nm, "_good"}, int'(bus.pwr_good), 0);
    chk({nm, "_ack"}, int'(bus.down_ack), 0);
  endtask
  initial begin
    bus.vddiox_ok_a = 1'b0;
    bus.vddio_ok_a  = 1'b0;
    bus.down_req    = 1'b0;
    bus.fault_clr   = 1'b0;
    tick(2);
    rst = 1'b0;
    chk_reset("rst0");
    chk("rst0_fault", int'(bus.fault), 0);
    bus.vddiox_ok_a = 1'b1;
    bus.vddio_ok_a  = 1'b1;
    tick(3);
    chk("pu_debounce", int'(bus.state), 1);
    chk("pu_ret_held", int'(bus.pad_ret), 1);
    tick(4);
    chk("pu_ret_rel", int'(bus.pad_ret), 0);
    chk("pu_ioen_off", int'(bus.pad_ioen), 0);
    tick(2);
    chk("pu_ioen_on", int'(bus.pad_ioen), 1);
    tick(1);
    chk("pu_good_early", int'(bus.pwr_good), 0);
    tick(1);
    chk("pu_good", int'(bus.pwr_good), 1);
    chk("pu_on", int'(bus.state), 4);
    chk("pu_fault", int'(bus.fault), 0);
    bus.down_req = 1'b1;
    tick(1);
    chk("pd_ioen", int'(bus.pad_ioen), 0);
    chk("pd_good", int'(bus.pwr_good), 0);
    chk("pd_ret_open", int'(bus.pad_ret), 0);
    tick(2);
    chk("pd_ret", int'(bus.pad_ret), 1);
    chk("pd_ack_early", int'(bus.down_ack), 0);
    tick(2);
    chk("pd_ack", int'(bus.down_ack), 1);
    tick(3);
    chk("pd_hold", int'(bus.state), 7);
    bus.down_req = 1'b0;
    tick(1);
    chk("pd_off", int'(bus.state), 0);
    chk("pd_ack_clr", int'(bus.down_ack), 0);
    tick(1);
    chk("gl_debounce", int'(bus.state), 1);
    bus.vddio_ok_a = 1'b0;
    tick(1);
    bus.vddio_ok_a = 1'b1;
    tick(1);
    chk("gl_still_deb", int'(bus.state), 1);
    tick(1);
    chk("gl_off", int'(bus.state), 0);
    chk("gl_ret", int'(bus.pad_ret), 1);
    tick(1);
    chk("gl_redeb", int'(bus.state), 1);
    tick(3);
    chk("gl_full_deb", int'(bus.state), 1);
    tick(1);
    chk("gl_relret", int'(bus.state), 2);
    chk("gl_fault", int'(bus.fault), 0);
    tick(4);
    chk("gl_on", int'(bus.state), 4);
    bus.vddiox_ok_a = 1'b0;
    tick(2);
    chk("bo_not_yet", int'(bus.state), 4);
    tick(1);
    chk("bo_off", int'(bus.state), 0);
    chk("bo_ioen", int'(bus.pad_ioen), 0);
    chk("bo_ret", int'(bus.pad_ret), 1);
    chk("bo_good", int'(bus.pwr_good), 0);
    chk("bo_fault", int'(bus.fault), 1);
    bus.vddiox_ok_a = 1'b1;
    tick(2);
    chk("bo_sticky", int'(bus.fault), 1);
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    chk("bo_clr", int'(bus.fault), 0);
    wait_state(4, 40, "bo_repower");
    bus.vddiox_ok_a = 1'b0;
    tick(2);
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    chk("bo2_set_wins", int'(bus.fault), 1);
    chk("bo2_off", int'(bus.state), 0);
    bus.vddiox_ok_a = 1'b1;
    wait_state(4, 40, "bo2_repower");
    chk("bo2_good", int'(bus.pwr_good), 1);
    chk("bo2_fault_kept", int'(bus.fault), 1);
    bus.fault_clr = 1'b1;
    tick(1);
    bus.fault_clr = 1'b0;
    chk("bo2_clr", int'(bus.fault), 0);
    bus.down_req = 1'b1;
    wait_state(7, 40, "er_down");
    bus.down_req = 1'b0;
    wait_state(2, 40, "er_relret");
    bus.down_req = 1'b1;
    tick(1);
    bus.down_req = 1'b0;
    wait_state(4, 40, "er_on");
    chk("er_on_good", int'(bus.pwr_good), 1);
    tick(1);
    chk("er_on_one_cycle", int'(bus.state), 5);
    chk("er_good_drop", int'(bus.pwr_good), 0);
    wait_state(3, 60, "rm_en_io");
    rst = 1'b1;
    tick(1);
    chk_reset("rm");
    chk("rm_fault", int'(bus.fault), 0);
    rst = 1'b0;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/riio_pwr_seq.md
Name: riio_pwr_seq

Overview:
- Core-side sequencer for the EG1D80V pad ring. It consumes the supply-good indications of the VDDIOX and VDDIO rails and drives pad retention and output-enable controls in a fixed power-up and power-down order.
- It is the controlling end of the rails the supply pads deliver.
- It sits in the always-on core domain and feeds the ring-wide pad control nets.

Parameters:
- SYNC_STAGES, 2, flop stages on each asynchronous supply-good input (min 2).
- CNT_W, 8, width of the shared sequencing counter.
- DEBOUNCE_CYC, 100, cycles both rails must stay good before retention release (1..2^CNT_W-1).
- STEP_CYC, 16, cycles between successive sequencing steps (1..2^CNT_W-1).

Ports:
- clk  input  1  core clock; every flop is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- vddiox_ok_a  input  1  VDDIOX supply-good, asynchronous.
- vddio_ok_a  input  1  VDDIO supply-good, asynchronous.
- down_req  input  1  software power-down request, level.
- fault_clr  input  1  one-cycle pulse; clears fault.
- pad_ret  output  1  pad retention, 1 = pads frozen.
- pad_ioen  output  1  pad output-enable, 1 = drivers active.
- pwr_good  output  1  ring fully up.
- down_ack  output  1  power-down complete.
- fault  output  1  sticky brownout flag.
- state  output  3  current FSM state encoding.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=OFF(0), pad_ret=1, pad_ioen=0, pwr_good=0, down_ack=0, fault=0, counter=0, synchronizers=0.
- Reset taken in any state forces these values on the next edge. No step completes partially.
- Synchronizers: each _a input passes SYNC_STAGES flops. ok = AND of both synchronized bits. All decisions use the synchronized ok.
- Registered outputs: all outputs are registered and decoded from the state entered.
- State encodings: OFF=0, DEBOUNCE=1, REL_RET=2, EN_IO=3, ON=4, DIS_IO=5, SET_RET=6, DOWN=7.
- OFF: pad_ret=1, pad_ioen=0. If ok && !down_req → DEBOUNCE with cnt=0.
- DEBOUNCE: cnt increments. If !ok → OFF. If cnt==DEBOUNCE_CYC-1 && ok → REL_RET with cnt=0 and pad_ret=0.
- REL_RET: pad_ret=0, pad_ioen=0. When cnt==STEP_CYC-1 → EN_IO with cnt=0 and pad_ioen=1.
- EN_IO: pad_ioen=1. When cnt==STEP_CYC-1 → ON with pwr_good=1.
- ON: pad_ret=0, pad_ioen=1, pwr_good=1. Counter is held. If down_req → DIS_IO with cnt=0, pad_ioen=0, pwr_good=0.
- DIS_IO: pad_ret=0, pad_ioen=0. When cnt==STEP_CYC-1 → SET_RET with cnt=0 and pad_ret=1.
- SET_RET: pad_ret=1. When cnt==STEP_CYC-1 → DOWN with down_ack=1.
- DOWN: down_ack=1. When !down_req → OFF with down_ack=0.
- Brownout: !ok in REL_RET, EN_IO, ON, DIS_IO or SET_RET → OFF on the next edge.
  - Forces pad_ioen=0, pad_ret=1, pwr_good=0, down_ack=0 together.
  - Sets fault=1.
  - Brownout has priority over down_req and over a step completion in the same cycle.
- !ok in DOWN: state stays DOWN. Pads are already safe, so fault is not set.
- !ok in OFF or DEBOUNCE: never sets fault.
- Fault clear:
  - fault stays set until a fault_clr pulse.
  - fault_clr and a new brownout in the same cycle → fault=1 (set wins).
  - fault does not block re-power-up.
- Held down_req: down_req held high in OFF blocks power-up. Asserting down_req during DEBOUNCE, REL_RET or EN_IO is latched. The sequence completes to ON, then leaves for DIS_IO on the next cycle.
- Invariant: pad_ioen=1 implies pad_ret=0, in every cycle.
- Counter: never wraps. It clears on every state entry.
- Latency:
  - Async rise to DEBOUNCE entry: SYNC_STAGES+1 cycles.
  - Power-up from DEBOUNCE entry to pwr_good: DEBOUNCE_CYC+2·STEP_CYC cycles.

Test Plan (bench uses DEBOUNCE_CYC=4, STEP_CYC=2, SYNC_STAGES=2):
- Clean power-up: reset, then both ok_a=1 at cycle 0.
  - DEBOUNCE at cycle 3, pad_ret=0 at cycle 7, pad_ioen=1 at cycle 9, pwr_good=1 at cycle 11.
  - fault stays 0.
- Glitch in debounce: vddio_ok_a low for 1 cycle, two cycles after DEBOUNCE entry.
  - Returns to OFF; pad_ret stays 1.
  - Full debounce restarts after recovery; fault=0.
- Orderly power-down: down_req=1 in ON.
  - pad_ioen=0 and pwr_good=0 after 1 cycle; pad_ret=1 2 cycles later; down_ack=1 2 cycles after that.
  - down_req=0 → OFF and down_ack=0 next cycle.
- Brownout in ON: vddiox_ok_a drops.
  - 3 cycles later: state=OFF, pad_ioen=0, pad_ret=1, fault=1.
  - fault_clr pulse → fault=0. Simultaneous fault_clr with a second brownout → fault stays 1.
- Early request: down_req asserted during REL_RET.
  - Reaches ON for exactly 1 cycle, then the DIS_IO path.
  - Invariant checked every cycle.
- Reset mid-sequence: rst=1 in EN_IO → all outputs at reset values next edge, state=0.
